// File: rtl/sum16_seq.sv
// Nibble-serial adder controller: adds two 4*NIB-bit operands one nibble per
// clock through a pair of sum4b slices, chaining a registered carry between nibbles.

module sum4b (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [3:0] o_s,
    output logic       o_c
);
    assign {o_c, o_s} = {1'b0, i_a} + {1'b0, i_b};
endmodule

module sum16_seq #(
    parameter int NIB = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [4*NIB-1:0] xi,
    input  logic [4*NIB-1:0] yi,
    output logic           busy,
    output logic           done,
    output logic [4*NIB-1:0] zi,
    output logic           co
);
    localparam int W  = 4 * NIB;
    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_xr;
    logic [W-1:0]  r_yr;
    logic [W-1:0]  r_zi;
    logic [CW-1:0] r_cnt;
    logic          r_cr;
    logic          r_co;

    logic [3:0]    w_xn;
    logic [3:0]    w_yn;
    logic [3:0]    w_s1;
    logic [3:0]    w_s2;
    logic          w_c1;
    logic          w_c2;
    logic          w_cn;
    logic          w_last;

    assign w_xn   = r_xr[{r_cnt, 2'b00} +: 4];
    assign w_yn   = r_yr[{r_cnt, 2'b00} +: 4];
    assign w_last = (r_cnt == CW'(NIB - 1));
    // c1 and c2 are mutually exclusive, so OR gives the nibble carry
    assign w_cn   = w_c1 | w_c2;

    sum4b u_add_a (
        .i_a (w_xn),
        .i_b (w_yn),
        .o_s (w_s1),
        .o_c (w_c1)
    );

    sum4b u_add_b (
        .i_a (w_s1),
        .i_b ({3'b000, r_cr}),
        .o_s (w_s2),
        .o_c (w_c2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xr  <= '0;
            r_yr  <= '0;
            r_zi  <= '0;
            r_cnt <= '0;
            r_cr  <= 1'b0;
            r_co  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_xr  <= xi;
                        r_yr  <= yi;
                        r_zi  <= '0;
                        r_cnt <= '0;
                        r_cr  <= 1'b0;
                        r_co  <= 1'b0;
                    end
                end
                S_RUN: begin
                    for (int n = 0; n < NIB; n++) begin
                        if (r_cnt == n[CW-1:0]) r_zi[4*n +: 4] <= w_s2;
                    end
                    r_cr  <= w_cn;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_co <= w_cn;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign zi   = r_zi;
    assign co   = r_co;

endmodule

// File: tb/tb_sum16_seq.sv
// Bench for sum16_seq: NIB=4 and NIB=2 instances checked against plain
// (x+y) arithmetic and the start/done timing rules.

module tb_sum16_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] xi, yi, zi;
    logic        busy, done, co;
    logic        start2;
    logic [7:0]  x2, y2, z2;
    logic        busy2, done2, co2;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sum16_seq #(.NIB(4)) dut (
        .clk(clk), .rst(rst), .start(start), .xi(xi), .yi(yi),
        .busy(busy), .done(done), .zi(zi), .co(co)
    );

    sum16_seq #(.NIB(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .xi(x2), .yi(y2),
        .busy(busy2), .done(done2), .zi(z2), .co(co2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic run4(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] exp;
        int lat, bc;
        exp = {1'b0, x} + {1'b0, y};
        @(negedge clk); start = 1'b1; xi = x; yi = y;
        @(posedge clk); #1; start = 1'b0;
        lat = 0; bc = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(negedge clk); xi = 16'($urandom); yi = 16'($urandom);
            @(posedge clk); #1;
            lat++;
            if (busy) bc++;
        end
        check("latency4", lat, 4);
        check("busy_cycles4", bc, 4);
        check("zi4", zi, exp[15:0]);
        check("co4", co, exp[16]);
        @(posedge clk); #1;
        check("done_pulse4", {busy, done}, 2'b00);
        check("zi_hold4", {co, zi}, exp);
    endtask

    task automatic run2(input logic [7:0] x, input logic [7:0] y);
        logic [8:0] exp;
        int lat;
        exp = {1'b0, x} + {1'b0, y};
        @(negedge clk); start2 = 1'b1; x2 = x; y2 = y;
        @(posedge clk); #1; start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 20) begin
            @(negedge clk); x2 = 8'($urandom); y2 = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check("latency2", lat, 2);
        check("sum2", {co2, z2}, exp);
        @(posedge clk); #1;
        check("done_pulse2", {busy2, done2}, 2'b00);
    endtask

    initial begin
        logic [15:0] hx, hy;
        logic [16:0] hexp;
        int ph;

        rst = 1'b1; start = 1'b0; xi = '0; yi = '0;
        start2 = 1'b0; x2 = '0; y2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {busy, done, co, zi}, 19'd0);
        check("reset_state2", {busy2, done2, co2, z2}, 11'd0);
        @(negedge clk); rst = 1'b0;

        // Directed operands
        run4(16'h1234, 16'h4321);
        run4(16'h000F, 16'h0001);
        run4(16'h0FFF, 16'h0001);
        run4(16'hFFFF, 16'h0001);
        run4(16'hFFFF, 16'hFFFF);
        run4(16'h0000, 16'h0000);

        // Start held high with operands changing every cycle
        for (int e = 0; e < 18; e++) begin
            @(negedge clk);
            start = 1'b1; xi = 16'($urandom); yi = 16'($urandom);
            if (e % 6 == 0) begin
                hx = xi; hy = yi;
                hexp = {1'b0, hx} + {1'b0, hy};
            end
            @(posedge clk); #1;
            ph = e % 6;
            check("held_ctrl", {busy, done}, {(ph <= 3), (ph == 4)});
            if (ph == 4) check("held_sum", {co, zi}, hexp);
        end
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;

        // Reset on the second RUN edge
        @(negedge clk); start = 1'b1; xi = 16'hFFFF; yi = 16'h0001;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rst_midrun", {busy, done, co, zi}, 19'd0);
        @(negedge clk); rst = 1'b0;
        run4(16'h0008, 16'h0008);

        // Partial result visible, then wiped by reset
        @(negedge clk); start = 1'b1; xi = 16'h1234; yi = 16'h1111;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("partial_zi", zi, 16'h0045);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rst_partial", {busy, done, co, zi}, 19'd0);

        // Reset wins over start on the same edge
        @(negedge clk); start = 1'b1; xi = 16'h1111; yi = 16'h1111;
        @(posedge clk); #1;
        check("rst_over_start", {busy, done}, 2'b00);
        @(negedge clk); rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst", {busy, done, co, zi}, 19'd0);

        for (int i = 0; i < 60; i++) run4(16'($urandom), 16'($urandom));

        // NIB=2 instance
        run2(8'hFF, 8'h01);
        run2(8'hFF, 8'hFF);
        run2(8'h00, 8'h00);
        run2(8'h0F, 8'h01);
        for (int i = 0; i < 150; i++) run2(8'($urandom), 8'($urandom));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
